// File: rtl/serial_word_deser.sv
// Serial-to-parallel word rebuilder: sync-aligned framing, one-deep valid/ready
// output buffer, and a sticky overrun flag for words dropped while the buffer is full.
module serial_word_deser #(
    parameter int WIDTH        = 4,
    parameter bit MSB_FIRST    = 1'b1,
    parameter bit REQUIRE_SYNC = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sdi_i,
    input  logic                       sdi_valid_i,
    input  logic                       sync_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       dout_valid_o,
    input  logic                       dout_ready_i,
    output logic                       overrun_o,
    input  logic                       clr_overrun_i,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam state_e RESET_STATE = REQUIRE_SYNC ? ST_HUNT : ST_SHIFT;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              complete_s;
    logic              ovr_set_s;

    // Shifting into an all-zero register also yields the "fresh word" start value.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        logic [WIDTH-1:0] res;
        if (MSB_FIRST) begin
            res = {cur[WIDTH-2:0], b};
        end else begin
            res = {b, cur[WIDTH-1:1]};
        end
        return res;
    endfunction

    // Framing FSM next state: hunting for sync, accumulating bits, detecting completion.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        complete_s = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (sdi_valid_i && sync_i) begin
                    shift_d = shift_in({WIDTH{1'b0}}, sdi_i);
                    cnt_d   = CNT_ONE;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_SHIFT: begin
                if (sdi_valid_i && sync_i) begin
                    shift_d = shift_in({WIDTH{1'b0}}, sdi_i);
                    cnt_d   = CNT_ONE;
                end else if (sdi_valid_i && (cnt_q == LAST_IDX)) begin
                    shift_d    = shift_in(shift_q, sdi_i);
                    cnt_d      = {CW{1'b0}};
                    complete_s = 1'b1;
                end else if (sdi_valid_i) begin
                    shift_d = shift_in(shift_q, sdi_i);
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = RESET_STATE;
                shift_d = {WIDTH{1'b0}};
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // Output buffer: load, same-cycle replace, consume, and overrun set/clear (set wins).
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        ovr_set_s = complete_s && valid_q && !dout_ready_i;
        if (complete_s && (!valid_q || dout_ready_i)) begin
            dout_d  = shift_d;
            valid_d = 1'b1;
        end else if (!complete_s && valid_q && dout_ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (ovr_set_s) begin
            ovr_d = 1'b1;
        end else if (clr_overrun_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_STATE;
            shift_q <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            dout_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign overrun_o    = ovr_q;
    assign bit_cnt_o    = cnt_q;

endmodule
